// File: rtl/bus_arbiter_16_pkg.sv
// Shared types and defaults for the 4-way round-robin bus arbiter.
// Replaces the old arbiter_defs.v include.
package bus_arbiter_16_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned MAX_HOLD_DEFAULT = 4;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_16_mux.sv
// 16-bit 2:1 mux primitive and the 4:1 data select built from three of them.
module mux_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] y
);

    assign y = sel ? b : a;

endmodule

module mux_4way_16 (
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic [15:0] d2,
    input  logic [15:0] d3,
    input  logic [1:0]  sel,
    output logic [15:0] y
);

    logic [15:0] lo;
    logic [15:0] hi;

    mux_16 u_lo  (.a(d0), .b(d1), .sel(sel[0]), .y(lo));
    mux_16 u_hi  (.a(d2), .b(d3), .sel(sel[0]), .y(hi));
    mux_16 u_out (.a(lo), .b(hi), .sel(sel[1]), .y(y));

endmodule

// File: rtl/bus_arbiter_16_rr_pick_4.sv
// Round-robin search: first asserted request starting at ptr, wrapping mod 4.
module rr_pick_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_16.sv
// Round-robin arbiter sharing one registered 16-bit valid/ready channel
// between four requesters, with a per-grant beat limit of MAX_HOLD.
module bus_arbiter_16
    import bus_arbiter_16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic [15:0] data3,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [3:0] HOLD = 4'(MAX_HOLD);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  owner;
    logic [1:0]  ptr;
    logic [3:0]  count;
    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [15:0] sel_data;
    logic        out_free;
    logic        beat;
    logic        last_beat;
    logic        release_now;

    rr_pick_4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    mux_4way_16 u_sel (
        .d0  (data0),
        .d1  (data1),
        .d2  (data2),
        .d3  (data3),
        .sel (owner),
        .y   (sel_data)
    );

    // A beat is accepted whenever the output register is empty or drained this cycle.
    assign out_free    = !out_valid || out_ready;
    assign beat        = (state == BUSY) && req[owner] && out_free;
    assign last_beat   = beat && ((count + 4'd1) == HOLD);
    assign release_now = (state == BUSY) && (!req[owner] || last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found)  state_nxt = BUSY;
            BUSY:    if (release_now) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        ack = '0;
        if (state == BUSY) begin
            gnt = onehot4(owner);
            if (beat) begin
                ack = onehot4(owner);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= '0;
            ptr   <= '0;
            count <= '0;
        end else if (state == IDLE) begin
            if (pick_found) begin
                owner <= pick_idx;
                count <= '0;
            end
        end else if (release_now) begin
            ptr   <= owner + 2'd1;
            count <= '0;
        end else if (beat) begin
            count <= count + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (beat) begin
            out_data  <= sel_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_16.sv
// Randomized and directed bench for bus_arbiter_16: a rule-level model predicts
// grants/acks and queues accepted words; a monitor checks words as they drain.
module tb_bus_arbiter_16;

    localparam int unsigned HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] data0, data1, data2, data3;
    logic [3:0]  gnt, ack;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_valid;

    always #5 clk = ~clk;

    bus_arbiter_16 #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .gnt       (gnt),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input int i);
        case (i)
            0:       return data0;
            1:       return data1;
            2:       return data2;
            default: return data3;
        endcase
    endfunction

    // Reference model: evaluated mid-cycle with the inputs that the next rising edge samples.
    always @(negedge clk) begin
        logic [3:0] e_gnt;
        logic [3:0] e_ack;
        bit         a;
        bit         hit;
        if (!rst_n) begin
            m_busy  = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_valid = 0;
            exp_q.delete();
            check("rst_gnt", gnt, 0);
            check("rst_ack", ack, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
        end else begin
            e_gnt = '0;
            e_ack = '0;
            a     = 0;
            if (m_busy) begin
                e_gnt = 4'b0001 << m_owner;
                a     = req[m_owner] && (!m_valid || out_ready);
                if (a) e_ack = e_gnt;
            end
            check("gnt", gnt, e_gnt);
            check("ack", ack, e_ack);
            check("out_valid", out_valid, m_valid);
            if (a) exp_q.push_back(word_of(m_owner));

            if (!m_busy) begin
                if (req != 0) begin
                    hit = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (!hit && req[(m_ptr + k) % 4]) begin
                            hit     = 1;
                            m_owner = (m_ptr + k) % 4;
                        end
                    end
                    m_busy = 1;
                    m_cnt  = 0;
                end
                if (m_valid && out_ready) m_valid = 0;
            end else begin
                if (a) begin
                    m_valid = 1;
                    m_cnt++;
                end else if (m_valid && out_ready) begin
                    m_valid = 0;
                end
                if (!req[m_owner] || (a && m_cnt == HOLD)) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 4;
                    m_cnt  = 0;
                end
            end
        end
    end

    // Monitor: the word presented must be the oldest accepted one; pop it when consumed.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_data: got %0h with no accepted word expected at %0t", out_data, $time);
            end else begin
                check("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_gnt", gnt, 0);
        check("async_ack", ack, 0);
        check("async_out_valid", out_valid, 0);
        check("async_out_data", out_data, 0);
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        data0     = '0;
        data1     = '0;
        data2     = '0;
        data3     = '0;
        out_ready = 1'b1;
        step(2);
        rst_n = 1'b1;

        // all requesters, full throughput
        data0 = 16'h0000; data1 = 16'h0001; data2 = 16'h0002; data3 = 16'h0003;
        req = 4'b1111;
        step(24);
        req = 4'b0000;
        step(3);

        // one-cycle pulse: granted but never acked
        data2 = 16'hBEEF;
        req = 4'b0100;
        step(1);
        req = 4'b0000;
        step(4);

        // stall after the first beat, then drain the rest of the budget
        data1 = 16'h1234;
        out_ready = 1'b0;
        req = 4'b0010;
        step(6);
        out_ready = 1'b1;
        step(6);
        req = 4'b0000;
        step(3);

        // owner drops mid-stream while others wait
        req = 4'b0100;
        step(1);
        req = 4'b1101;
        step(2);
        req = 4'b1001;
        step(12);
        req = 4'b0000;
        step(3);

        // reset while busy with a held word
        out_ready = 1'b0;
        req = 4'b0001;
        step(3);
        do_reset();
        out_ready = 1'b1;
        req = 4'b0010;
        step(4);
        req = 4'b0000;
        step(3);

        // back-to-back beats with changing data
        data0 = 16'd1;
        req = 4'b0001;
        step(1);
        for (int v = 2; v <= 5; v++) begin
            step(1);
            data0 = 16'(v);
        end
        req = 4'b0000;
        step(4);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            data0 = 16'($urandom);
            data1 = 16'($urandom);
            data2 = 16'($urandom);
            data3 = 16'($urandom);
            if ($urandom_range(699) == 0) do_reset();
            step(1);
        end

        req = 4'b0000;
        out_ready = 1'b1;
        step(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
